// File: rtl/upg_mode_ctrl.sv
// upg_mode_ctrl: run/program mode controller.
// Debounces the program-mode button and sequences the resets of the UART
// programmer and the CPU core. The CPU is held in reset while programming
// and for a fixed drain period after programming or a system reset.

module upg_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned POST_RST_CYCLES = 16,
    parameter int unsigned CNT_W           = 22
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_startPg,
    input  logic i_upgDone,
    output logic o_upgRst,
    output logic o_cpuRst,
    output logic o_mode
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PROG     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam int unsigned MAX_CYC =
        (DEBOUNCE_CYCLES > POST_RST_CYCLES) ? DEBOUNCE_CYCLES : POST_RST_CYCLES;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(POST_RST_CYCLES - 1);

    // The counter must reach the larger terminal count without wrapping.
    generate
        if (((MAX_CYC - 1) >> CNT_W) != 0) begin : g_cntWidthCheck
            $error("upg_mode_ctrl: CNT_W too small for DEBOUNCE_CYCLES/POST_RST_CYCLES");
        end
    endgenerate

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             r_armed;
    logic             w_nextArmed;
    logic             r_syncMeta;
    logic             r_syncPg;
    logic             r_upgRst;
    logic             r_cpuRst;
    logic             r_mode;
    logic             w_nextUpgRst;
    logic             w_nextCpuRst;
    logic             w_nextMode;

    // Two-flop synchronizer bringing the raw button into the clk domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_syncMeta <= 1'b0;
            r_syncPg   <= 1'b0;
        end else begin
            r_syncMeta <= i_startPg;
            r_syncPg   <= r_syncMeta;
        end
    end

    // State, counter, arm flag and registered outputs; reset lands in DRAIN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_DRAIN;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_upgRst <= 1'b1;
            r_cpuRst <= 1'b1;
            r_mode   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_armed  <= w_nextArmed;
            r_upgRst <= w_nextUpgRst;
            r_cpuRst <= w_nextCpuRst;
            r_mode   <= w_nextMode;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // update on the same edge as the state register.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextArmed  = r_armed;
        w_nextUpgRst = 1'b1;
        w_nextCpuRst = 1'b1;
        w_nextMode   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (!r_syncPg) begin
                    w_nextArmed = 1'b1;
                end
                if (r_syncPg && r_armed) begin
                    w_nextState = ST_DEBOUNCE;
                    w_nextCnt   = '0;
                    w_nextArmed = 1'b0;
                end
            end
            ST_DEBOUNCE: begin
                if (!r_syncPg) begin
                    w_nextState = ST_RUN;
                end else if (r_cnt == DEB_LAST) begin
                    w_nextState = ST_PROG;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            ST_PROG: begin
                if (i_upgDone) begin
                    w_nextState = ST_DRAIN;
                    w_nextCnt   = '0;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_nextState = ST_RUN;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = ST_DRAIN;
                w_nextCnt   = '0;
            end
        endcase

        case (w_nextState)
            ST_RUN, ST_DEBOUNCE: begin
                w_nextCpuRst = 1'b0;
            end
            ST_PROG: begin
                w_nextUpgRst = 1'b0;
                w_nextMode   = 1'b1;
            end
            default: begin
                w_nextUpgRst = 1'b1;
                w_nextCpuRst = 1'b1;
                w_nextMode   = 1'b0;
            end
        endcase
    end

    assign o_upgRst = r_upgRst;
    assign o_cpuRst = r_cpuRst;
    assign o_mode   = r_mode;

endmodule
